mem_req_arbiter: RTL and testbench



---
 rtl/mem_req_arbiter_pkg.sv | 15 +
 rtl/mem_req_arbiter_if.sv | 23 ++
 rtl/mem_req_arbiter.sv | 107 ++++++++++
 tb/tb_mem_req_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// rtl/mem_req_arbiter_pkg.sv - shared encodings for the instruction/data memory request arbiter
package mem_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - request/response bus shared by requesters and the memory side
interface mem_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    // slave: the side that accepts requests; master: the side that issues them
    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - two-requester, single-outstanding memory arbiter with data priority
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic               clk,
    input logic               reset,
    mem_req_arbiter_if.slave  inst,
    mem_req_arbiter_if.slave  data,
    mem_req_arbiter_if.master mst
);

    arb_state_t  state;
    logic        owner;
    logic [2:0]  starve_cnt;
    logic        lat_wr;
    logic [1:0]  lat_size;
    logic [3:0]  lat_wstrb;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic in_idle;
    logic starved;
    logic grant_data;
    logic grant_inst;
    logic resp_done;
    logic issuing;

    // data has priority unless inst has been passed over STARVE_LIMIT times in a row
    assign in_idle    = (state == ST_IDLE) && !reset;
    assign starved    = (starve_cnt == 3'(STARVE_LIMIT)) && inst.req;
    assign grant_data = in_idle && data.req && !starved;
    assign grant_inst = in_idle && inst.req && !grant_data;
    assign resp_done  = (state == ST_RESP) && mst.data_ok && !reset;
    assign issuing    = (state == ST_REQ) && !reset;

    assign inst.addr_ok = grant_inst;
    assign data.addr_ok = grant_data;
    assign inst.data_ok = resp_done && (owner == OWN_INST);
    assign data.data_ok = resp_done && (owner == OWN_DATA);
    assign inst.rdata   = (owner == OWN_INST) ? mst.rdata : 32'h0;
    assign data.rdata   = (owner == OWN_DATA) ? mst.rdata : 32'h0;

    assign mst.req   = issuing;
    assign mst.wr    = issuing && lat_wr;
    assign mst.size  = issuing ? lat_size  : 2'b00;
    assign mst.wstrb = issuing ? lat_wstrb : 4'h0;
    assign mst.addr  = issuing ? lat_addr  : 32'h0;
    assign mst.wdata = issuing ? lat_wdata : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            owner <= OWN_DATA;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_data) begin
                        owner <= OWN_DATA;
                        state <= ST_REQ;
                    end else if (grant_inst) begin
                        owner <= OWN_INST;
                        state <= ST_REQ;
                    end
                end
                ST_REQ:  if (mst.addr_ok) state <= ST_RESP;
                ST_RESP: if (mst.data_ok) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_wr    <= 1'b0;
            lat_size  <= 2'b00;
            lat_wstrb <= 4'h0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
        end else if (grant_data) begin
            lat_wr    <= data.wr;
            lat_size  <= data.size;
            lat_wstrb <= data.wstrb;
            lat_addr  <= data.addr;
            lat_wdata <= data.wdata;
        end else if (grant_inst) begin
            lat_wr    <= inst.wr;
            lat_size  <= inst.size;
            lat_wstrb <= inst.wstrb;
            lat_addr  <= inst.addr;
            lat_wdata <= inst.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 3'd0;
        end else if (state == ST_IDLE) begin
            if (grant_inst || !inst.req)
                starve_cnt <= 3'd0;
            else if (grant_data && (starve_cnt != 3'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + 3'd1;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    mem_req_arbiter_if inst_bus ();
    mem_req_arbiter_if data_bus ();
    mem_req_arbiter_if mst_bus ();

    mem_req_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .inst  (inst_bus),
        .data  (data_bus),
        .mst   (mst_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    // zero-wait slave: addr_ok in the REQ cycle, data_ok in the following cycle
    task automatic zero_tail(input string tag, input logic [31:0] rd, input logic is_inst);
        mst_bus.addr_ok = 1'b1;
        smp;
        check({tag, "_mreq"}, 32'(mst_bus.req), 32'd1);
        tick;
        mst_bus.addr_ok = 1'b0;
        mst_bus.data_ok = 1'b1;
        mst_bus.rdata   = rd;
        smp;
        check({tag, "_dok"},  32'(is_inst ? inst_bus.data_ok : data_bus.data_ok), 32'd1);
        check({tag, "_rd"},   is_inst ? inst_bus.rdata : data_bus.rdata, rd);
        check({tag, "_xdok"}, 32'(is_inst ? data_bus.data_ok : inst_bus.data_ok), 32'd0);
        tick;
        mst_bus.data_ok = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1;
        inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 0; inst_bus.wstrb = 0;
        inst_bus.addr = 0; inst_bus.wdata = 0;
        data_bus.req = 0; data_bus.wr = 0; data_bus.size = 0; data_bus.wstrb = 0;
        data_bus.addr = 0; data_bus.wdata = 0;
        mst_bus.addr_ok = 0; mst_bus.data_ok = 0; mst_bus.rdata = 0;

        // reset: requests ignored, everything idle
        tick;
        inst_bus.req = 1'b1;
        smp;
        check("rst_inst_aok", 32'(inst_bus.addr_ok), 32'd0);
        tick;
        smp;
        check("rst_state", 32'(dut.state), 32'(ST_IDLE));
        check("rst_owner", 32'(dut.owner), 32'(OWN_DATA));
        check("rst_starve", 32'(dut.starve_cnt), 32'd0);
        check("rst_mreq", 32'(mst_bus.req), 32'd0);
        check("rst_laddr", dut.lat_addr, 32'h0);
        tick;
        reset = 1'b0;
        inst_bus.req = 1'b0;

        // A: single instruction fetch, zero-wait slave
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1C000000; inst_bus.size = 2'd2;
        smp;
        check("a_inst_aok", 32'(inst_bus.addr_ok), 32'd1);
        check("a_data_aok", 32'(data_bus.addr_ok), 32'd0);
        tick;
        inst_bus.req = 1'b0;
        mst_bus.addr_ok = 1'b1;
        smp;
        check("a_mreq", 32'(mst_bus.req), 32'd1);
        check("a_maddr", mst_bus.addr, 32'h1C000000);
        check("a_mwr", 32'(mst_bus.wr), 32'd0);
        check("a_inst_aok1", 32'(inst_bus.addr_ok), 32'd0);
        tick;
        mst_bus.addr_ok = 1'b0; mst_bus.data_ok = 1'b1; mst_bus.rdata = 32'h02800400;
        smp;
        check("a_inst_dok", 32'(inst_bus.data_ok), 32'd1);
        check("a_inst_rd", inst_bus.rdata, 32'h02800400);
        check("a_data_dok", 32'(data_bus.data_ok), 32'd0);
        check("a_data_rd", data_bus.rdata, 32'h0);
        check("a_mreq2", 32'(mst_bus.req), 32'd0);
        tick;
        mst_bus.data_ok = 1'b0;
        smp;
        check("a_idle_mreq", 32'(mst_bus.req), 32'd0);
        check("a_idle_maddr", mst_bus.addr, 32'h0);
        check("a_idle_state", 32'(dut.state), 32'(ST_IDLE));
        tick;

        // B: simultaneous requests, data write wins
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1C000004;
        data_bus.req = 1'b1; data_bus.wr = 1'b1; data_bus.size = 2'd2;
        data_bus.wstrb = 4'hF; data_bus.addr = 32'h00001000; data_bus.wdata = 32'hDEADBEEF;
        smp;
        check("b_data_aok", 32'(data_bus.addr_ok), 32'd1);
        check("b_inst_aok", 32'(inst_bus.addr_ok), 32'd0);
        tick;
        data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.wstrb = 4'h0;
        mst_bus.addr_ok = 1'b1;
        smp;
        check("b_mwr", 32'(mst_bus.wr), 32'd1);
        check("b_mwdata", mst_bus.wdata, 32'hDEADBEEF);
        check("b_maddr", mst_bus.addr, 32'h00001000);
        check("b_mwstrb", 32'(mst_bus.wstrb), 32'hF);
        check("b_inst_aok1", 32'(inst_bus.addr_ok), 32'd0);
        tick;
        mst_bus.addr_ok = 1'b0; mst_bus.data_ok = 1'b1; mst_bus.rdata = 32'h12345678;
        smp;
        check("b_data_dok", 32'(data_bus.data_ok), 32'd1);
        check("b_inst_dok", 32'(inst_bus.data_ok), 32'd0);
        check("b_inst_aok2", 32'(inst_bus.addr_ok), 32'd0);
        tick;
        mst_bus.data_ok = 1'b0;
        smp;
        check("b_inst_aok3", 32'(inst_bus.addr_ok), 32'd1);
        tick;
        inst_bus.req = 1'b0;
        zero_tail("b_inst", 32'h0000AAAA, 1'b1);

        // C: data held continuously, inst pending -> inst wins grant 5
        data_bus.req = 1'b1; data_bus.addr = 32'h00003000; data_bus.size = 2'd2;
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1C000400;
        for (int g = 1; g <= 5; g++) begin
            smp;
            check($sformatf("c_g%0d_cnt", g), 32'(dut.starve_cnt), 32'(g - 1));
            check($sformatf("c_g%0d_data", g), 32'(data_bus.addr_ok), (g < 5) ? 32'd1 : 32'd0);
            check($sformatf("c_g%0d_inst", g), 32'(inst_bus.addr_ok), (g < 5) ? 32'd0 : 32'd1);
            tick;
            if (g == 5) begin
                inst_bus.req = 1'b0;
                data_bus.req = 1'b0;
            end
            zero_tail($sformatf("c_g%0d", g), 32'h0000C000 + 32'(g), (g == 5));
        end
        smp;
        check("c_cnt_clr", 32'(dut.starve_cnt), 32'd0);
        tick;

        // D: slow slave, spurious data_ok in REQ, data request waits its turn
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1C000100;
        smp;
        check("d_acc", 32'(inst_bus.addr_ok), 32'd1);
        tick;
        inst_bus.req = 1'b0;
        data_bus.req = 1'b1; data_bus.addr = 32'h00002000;
        for (int i = 0; i < 3; i++) begin
            mst_bus.data_ok = (i == 1);
            smp;
            check($sformatf("d_w%0d_mreq", i), 32'(mst_bus.req), 32'd1);
            check($sformatf("d_w%0d_maddr", i), mst_bus.addr, 32'h1C000100);
            check($sformatf("d_w%0d_daok", i), 32'(data_bus.addr_ok), 32'd0);
            check($sformatf("d_w%0d_idok", i), 32'(inst_bus.data_ok), 32'd0);
            check($sformatf("d_w%0d_st", i), 32'(dut.state), 32'(ST_REQ));
            tick;
        end
        mst_bus.data_ok = 1'b0;
        mst_bus.addr_ok = 1'b1;
        smp;
        check("d_mreq_aok", 32'(mst_bus.req), 32'd1);
        tick;
        mst_bus.addr_ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            smp;
            check($sformatf("d_r%0d_mreq", i), 32'(mst_bus.req), 32'd0);
            check($sformatf("d_r%0d_daok", i), 32'(data_bus.addr_ok), 32'd0);
            check($sformatf("d_r%0d_idok", i), 32'(inst_bus.data_ok), 32'd0);
            tick;
        end
        mst_bus.data_ok = 1'b1; mst_bus.rdata = 32'hCAFEF00D;
        smp;
        check("d_idok", 32'(inst_bus.data_ok), 32'd1);
        check("d_ird", inst_bus.rdata, 32'hCAFEF00D);
        check("d_ddok", 32'(data_bus.data_ok), 32'd0);
        check("d_daok_resp", 32'(data_bus.addr_ok), 32'd0);
        tick;
        mst_bus.data_ok = 1'b0;
        smp;
        check("d_daok_idle", 32'(data_bus.addr_ok), 32'd1);
        check("d_idok_idle", 32'(inst_bus.data_ok), 32'd0);
        tick;
        data_bus.req = 1'b0;
        zero_tail("d_data", 32'h0BADF00D, 1'b0);

        // E: reset while in RESP abandons the transaction
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1C000200;
        smp;
        check("e_acc", 32'(inst_bus.addr_ok), 32'd1);
        tick;
        inst_bus.req = 1'b0;
        mst_bus.addr_ok = 1'b1;
        smp;
        tick;
        mst_bus.addr_ok = 1'b0;
        reset = 1'b1;
        smp;
        check("e_rst_st", 32'(dut.state), 32'(ST_RESP));
        check("e_rst_idok", 32'(inst_bus.data_ok), 32'd0);
        tick;
        reset = 1'b0;
        mst_bus.data_ok = 1'b1; mst_bus.rdata = 32'h55556666;
        smp;
        check("e_late_idok", 32'(inst_bus.data_ok), 32'd0);
        check("e_late_ddok", 32'(data_bus.data_ok), 32'd0);
        check("e_late_st", 32'(dut.state), 32'(ST_IDLE));
        tick;
        mst_bus.data_ok = 1'b0;
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1C000300;
        smp;
        check("e_new_st", 32'(dut.state), 32'(ST_IDLE));
        check("e_new_acc", 32'(inst_bus.addr_ok), 32'd1);
        tick;
        inst_bus.req = 1'b0;
        zero_tail("e_inst", 32'h11112222, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
